// File: rtl/memory_responder.sv
// memory_responder
//   Arbitrates datapath instruction-fetch and data requests onto a single
//   fixed-latency RAM port. Data requests win over fetches. Each access holds
//   the RAM strobes, address and store data for LAT cycles, and then spends
//   one response cycle in which ihit or dhit pulses.
//
// Parameters
//   LAT        RAM access cycles per request (1..15)
//
// Ports
//   CLK        sole clock, rising edge
//   nRST       synchronous reset, active high
//   imemREN    instruction fetch request      imemaddr  fetch byte address
//   dmemREN    data read request              dmemWEN   data write request
//   dmemaddr   data byte address              dmemstore data to write
//   halt       datapath halted: blocks new fetches only
//   ihit       fetch complete (one cycle)     imemload  fetched word (held)
//   dhit       data access complete           dmemload  loaded word (held)
//   ramREN     RAM read strobe                ramWEN    RAM write strobe
//   ramaddr    RAM address                    ramstore  RAM write data
//   ramload    RAM read data, valid on the last cycle of the access window
//
// Build option
//   MEMORY_RESPONDER_IBUF_EN  adds a one-entry fetch buffer. A fetch whose
//   word address matches the buffered tag completes without touching RAM.
module memory_responder #(
  parameter int unsigned LAT = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload
);

  typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_e;

  localparam logic [3:0] LAST_CNT = 4'(LAT - 1);

  state_e      state_q,     state_d;
  logic [3:0]  cnt_q,       cnt_d;
  logic [31:0] addr_q,      addr_d;
  logic [31:0] store_q,     store_d;
  logic        wr_q,        wr_d;
  logic        ihit_q,      ihit_d;
  logic        dhit_q,      dhit_d;
  logic [31:0] imemload_q,  imemload_d;
  logic [31:0] dmemload_q,  dmemload_d;
  logic        ram_ren_q,   ram_ren_d;
  logic        ram_wen_q,   ram_wen_d;
  logic [31:0] ram_addr_q,  ram_addr_d;
  logic [31:0] ram_store_q, ram_store_d;

  logic d_req;
  logic i_req;

  assign d_req = dmemREN | dmemWEN;
  assign i_req = imemREN & ~halt;

`ifdef MEMORY_RESPONDER_IBUF_EN
  logic        ibuf_valid_q, ibuf_valid_d;
  logic [29:0] ibuf_tag_q,   ibuf_tag_d;
  logic [31:0] ibuf_data_q,  ibuf_data_d;
  logic        ibuf_hit;

  assign ibuf_hit = ibuf_valid_q && (ibuf_tag_q == imemaddr[31:2]);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    store_d     = store_q;
    wr_d        = wr_q;
    ihit_d      = 1'b0;
    dhit_d      = 1'b0;
    imemload_d  = imemload_q;
    dmemload_d  = dmemload_q;
    ram_ren_d   = 1'b0;
    ram_wen_d   = 1'b0;
    ram_addr_d  = '0;
    ram_store_d = '0;
`ifdef MEMORY_RESPONDER_IBUF_EN
    ibuf_valid_d = ibuf_valid_q;
    ibuf_tag_d   = ibuf_tag_q;
    ibuf_data_d  = ibuf_data_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (d_req) begin
          // Read+write together is treated as a write.
          state_d     = DACC;
          cnt_d       = '0;
          addr_d      = dmemaddr;
          store_d     = dmemstore;
          wr_d        = dmemWEN;
          ram_wen_d   = dmemWEN;
          ram_ren_d   = ~dmemWEN;
          ram_addr_d  = dmemaddr;
          ram_store_d = dmemstore;
        end else if (i_req) begin
`ifdef MEMORY_RESPONDER_IBUF_EN
          if (ibuf_hit) begin
            // Buffered fetch: straight to the response cycle, RAM idle.
            state_d    = RESP;
            ihit_d     = 1'b1;
            imemload_d = ibuf_data_q;
          end else
`endif
          begin
            state_d    = IACC;
            cnt_d      = '0;
            addr_d     = imemaddr;
            store_d    = '0;
            wr_d       = 1'b0;
            ram_ren_d  = 1'b1;
            ram_addr_d = imemaddr;
          end
        end
      end

      IACC, DACC: begin
        if (cnt_q == LAST_CNT) begin
          // Last window cycle: ramload is valid now.
          state_d = RESP;
          if (state_q == IACC) begin
            ihit_d     = 1'b1;
            imemload_d = ramload;
`ifdef MEMORY_RESPONDER_IBUF_EN
            ibuf_valid_d = 1'b1;
            ibuf_tag_d   = addr_q[31:2];
            ibuf_data_d  = ramload;
`endif
          end else begin
            dhit_d = 1'b1;
            if (!wr_q) begin
              dmemload_d = ramload;
            end
`ifdef MEMORY_RESPONDER_IBUF_EN
            if (wr_q && ibuf_valid_q && (ibuf_tag_q == addr_q[31:2])) begin
              ibuf_valid_d = 1'b0;
            end
`endif
          end
        end else begin
          cnt_d       = cnt_q + 4'd1;
          ram_ren_d   = ~wr_q;
          ram_wen_d   = wr_q;
          ram_addr_d  = addr_q;
          ram_store_d = store_q;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      store_q     <= '0;
      wr_q        <= 1'b0;
      ihit_q      <= 1'b0;
      dhit_q      <= 1'b0;
      imemload_q  <= '0;
      dmemload_q  <= '0;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
`ifdef MEMORY_RESPONDER_IBUF_EN
      ibuf_valid_q <= 1'b0;
      ibuf_tag_q   <= '0;
      ibuf_data_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      store_q     <= store_d;
      wr_q        <= wr_d;
      ihit_q      <= ihit_d;
      dhit_q      <= dhit_d;
      imemload_q  <= imemload_d;
      dmemload_q  <= dmemload_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_store_q <= ram_store_d;
`ifdef MEMORY_RESPONDER_IBUF_EN
      ibuf_valid_q <= ibuf_valid_d;
      ibuf_tag_q   <= ibuf_tag_d;
      ibuf_data_q  <= ibuf_data_d;
`endif
    end
  end

  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign imemload = imemload_q;
  assign dmemload = dmemload_q;
  assign ramREN   = ram_ren_q;
  assign ramWEN   = ram_wen_q;
  assign ramaddr  = ram_addr_q;
  assign ramstore = ram_store_q;

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder (LAT = 2): reset values, a table of
// single transactions, hand-written multi-cycle sequences (arbitration,
// back-to-back requests, reset mid-access, fetch buffer) and a randomized run
// checked cycle by cycle against a transaction-level timing model.
module tb_memory_responder;

  localparam int unsigned LAT = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN, dmemREN, dmemWEN, halt;
  logic [31:0] imemaddr, dmemaddr, dmemstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN;
  logic [31:0] imemload, dmemload, ramaddr, ramstore;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  memory_responder #(.LAT(LAT)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .dmemREN  (dmemREN),
    .dmemWEN  (dmemWEN),
    .dmemaddr (dmemaddr),
    .dmemstore(dmemstore),
    .halt     (halt),
    .ihit     (ihit),
    .imemload (imemload),
    .dhit     (dhit),
    .dmemload (dmemload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload)
  );

  always #5 CLK = ~CLK;

  // After each call the bench sits 1 time unit into cycle 'cyc'.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b1;
    step();
    step();
    nRST = 1'b0;
    step();
  endtask

  // Issue one request in the current cycle (cycle 0), drop it in cycle 1,
  // and observe cycles 1..8.
  task automatic run_txn(input logic d_ren, input logic d_wen, input logic i_ren,
                         input logic hlt, input logic [31:0] addr,
                         input logic [31:0] store, input logic [31:0] rl,
                         output int ih, output int dh, output int rc,
                         output int wc, output int badaddr);
    dmemREN = d_ren; dmemWEN = d_wen; imemREN = i_ren; halt = hlt;
    dmemaddr = addr; imemaddr = addr; dmemstore = store; ramload = rl;
    ih = 0; dh = 0; rc = 0; wc = 0; badaddr = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) idle_inputs();
      if (ihit && ih == 0) ih = c;
      if (dhit && dh == 0) dh = c;
      if (ramREN) rc++;
      if (ramWEN) wc++;
      if ((ramREN || ramWEN) && (ramaddr !== addr)) badaddr++;
      if (ramWEN && (ramstore !== store)) badaddr++;
    end
  endtask

  typedef struct {
    logic        d_ren, d_wen, i_ren, hlt;
    logic [31:0] addr, store, rl;
    int          exp_ih, exp_dh, exp_rc, exp_wc;
    logic [31:0] exp_iload, exp_dload;
  } vec_t;

  vec_t tbl[6];

  // Transaction-level reference model state for the random phase.
  logic        t_active, t_is_i, t_wr, t_strobe;
  logic [31:0] t_addr, t_store, t_cap;
  int          t_start, t_hit, t_free;
  logic [31:0] e_iload, e_dload;
`ifdef MEMORY_RESPONDER_IBUF_EN
  logic        mb_valid;
  logic [29:0] mb_tag;
  logic [31:0] mb_data;
`endif

  initial begin : main
    int ih, dh, rc, wc, ba, both, h1, h2, dh_after;
    logic e_ren, e_wen, e_ihit, e_dhit;
    int n;

    idle_inputs();
    imemaddr = '0; dmemaddr = '0; dmemstore = '0; ramload = '0;
    nRST = 1'b1;
    step();
    step();
    // Reset state, reset still asserted.
    chk("rst_ihit", {31'b0, ihit}, 32'd0);
    chk("rst_dhit", {31'b0, dhit}, 32'd0);
    chk("rst_ramREN", {31'b0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_dmemload", dmemload, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    nRST = 1'b0;
    step();

    // ---------------- table-driven single transactions ----------------
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h40,  32'h0,        32'h2008_0005, 3, 0, 2, 0, 32'h2008_0005, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'hDEAD_BEEF, 32'h5555_5555, 0, 3, 0, 2, 32'h2008_0005, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0,        32'h1234_5678, 0, 3, 2, 0, 32'h2008_0005, 32'h1234_5678};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h204, 32'h0BAD_F00D, 32'h7777_7777, 0, 3, 0, 2, 32'h2008_0005, 32'h1234_5678};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h48,  32'h0,        32'h9999_9999, 0, 0, 0, 0, 32'h2008_0005, 32'h1234_5678};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h44,  32'h0,        32'hCAFE_F00D, 3, 0, 2, 0, 32'hCAFE_F00D, 32'h1234_5678};

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].d_ren, tbl[i].d_wen, tbl[i].i_ren, tbl[i].hlt, tbl[i].addr,
              tbl[i].store, tbl[i].rl, ih, dh, rc, wc, ba);
      chk($sformatf("vec%0d_ihit_cycle", i), ih, tbl[i].exp_ih);
      chk($sformatf("vec%0d_dhit_cycle", i), dh, tbl[i].exp_dh);
      chk($sformatf("vec%0d_ren_cycles", i), rc, tbl[i].exp_rc);
      chk($sformatf("vec%0d_wen_cycles", i), wc, tbl[i].exp_wc);
      chk($sformatf("vec%0d_addr_data", i), ba, 0);
      chk($sformatf("vec%0d_imemload", i), imemload, tbl[i].exp_iload);
      chk($sformatf("vec%0d_dmemload", i), dmemload, tbl[i].exp_dload);
    end

    // ---------------- D and I together: data first ----------------
    dmemREN = 1'b1; imemREN = 1'b1; dmemaddr = 32'h100; imemaddr = 32'h300;
    ramload = 32'hA1A1_A1A1;
    dh = 0; ih = 0; both = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (ihit && dhit) both++;
      if (dhit && dh == 0) begin dh = c; dmemREN = 1'b0; ramload = 32'hB2B2_B2B2; end
      if (ihit && ih == 0) begin ih = c; imemREN = 1'b0; end
    end
    chk("arb_dhit_cycle", dh, 3);
    chk("arb_ihit_cycle", ih, 7);
    chk("arb_both_hits", both, 0);
    chk("arb_dmemload", dmemload, 32'hA1A1_A1A1);
    chk("arb_imemload", imemload, 32'hB2B2_B2B2);

    // ---------------- request held high: back-to-back fetches ----------------
    imemREN = 1'b1; imemaddr = 32'h400; ramload = 32'h0000_1111;
    h1 = 0; h2 = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (ihit) begin
        if (h1 == 0) begin h1 = c; imemaddr = 32'h404; end
        else if (h2 == 0) begin h2 = c; imemREN = 1'b0; end
      end
    end
    chk("b2b_first_ihit", h1, 3);
    chk("b2b_second_ihit", h2, 7);

    // ---------------- reset in the middle of a data access ----------------
    dmemREN = 1'b1; dmemaddr = 32'h100; ramload = 32'h3333_3333;
    step();                 // cycle 1: DACC
    idle_inputs();
    step();                 // cycle 2: DACC
    nRST = 1'b1;
    step();                 // cycle 3
    chk("midrst_ihit", {31'b0, ihit}, 32'd0);
    chk("midrst_dhit", {31'b0, dhit}, 32'd0);
    chk("midrst_ramREN", {31'b0, ramREN}, 32'd0);
    chk("midrst_ramWEN", {31'b0, ramWEN}, 32'd0);
    chk("midrst_imemload", imemload, 32'd0);
    chk("midrst_dmemload", dmemload, 32'd0);
    chk("midrst_ramaddr", ramaddr, 32'd0);
    chk("midrst_ramstore", ramstore, 32'd0);
    nRST = 1'b0;
    dh_after = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (dhit) dh_after++;
    end
    chk("midrst_no_dhit", dh_after, 0);
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 32'h4444_4444, ih, dh, rc, wc, ba);
    chk("postrst_ihit_cycle", ih, 3);
    chk("postrst_imemload", imemload, 32'h4444_4444);

    // ---------------- fetch buffer sequence ----------------
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h6666_0001, ih, dh, rc, wc, ba);
    chk("ibuf_fill_ihit", ih, 3);
    chk("ibuf_fill_ren", rc, 2);
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h6666_0002, ih, dh, rc, wc, ba);
`ifdef MEMORY_RESPONDER_IBUF_EN
    chk("ibuf_hit_ihit", ih, 1);
    chk("ibuf_hit_ren", rc, 0);
    chk("ibuf_hit_imemload", imemload, 32'h6666_0001);
`else
    chk("ibuf_hit_ihit", ih, 3);
    chk("ibuf_hit_ren", rc, 2);
    chk("ibuf_hit_imemload", imemload, 32'h6666_0002);
`endif
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h1357_9BDF, 32'h0, ih, dh, rc, wc, ba);
    chk("ibuf_wr_dhit", dh, 3);
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h6666_0003, ih, dh, rc, wc, ba);
    chk("ibuf_inval_ihit", ih, 3);
    chk("ibuf_inval_ren", rc, 2);
    chk("ibuf_inval_imemload", imemload, 32'h6666_0003);

    // ---------------- randomized run against the timing model ----------------
    idle_inputs();
    do_reset();
    t_active = 1'b0; t_is_i = 1'b0; t_wr = 1'b0; t_strobe = 1'b0;
    t_addr = '0; t_store = '0; t_cap = '0;
    t_start = 0; t_hit = 0; t_free = cyc;
    e_iload = '0; e_dload = '0;
`ifdef MEMORY_RESPONDER_IBUF_EN
    mb_valid = 1'b0; mb_tag = '0; mb_data = '0;
`endif
    for (int k = 0; k < 600; k++) begin
      step();
      n = cyc;
      if (t_active && n == t_hit && !t_wr) begin
        if (t_is_i) e_iload = t_cap; else e_dload = t_cap;
      end
      e_ren  = t_active && t_strobe && n >= t_start && n < t_start + int'(LAT) && !t_wr;
      e_wen  = t_active && t_strobe && n >= t_start && n < t_start + int'(LAT) && t_wr;
      e_ihit = t_active && n == t_hit && t_is_i;
      e_dhit = t_active && n == t_hit && !t_is_i;
      chk("rnd_ihit", {31'b0, ihit}, {31'b0, e_ihit});
      chk("rnd_dhit", {31'b0, dhit}, {31'b0, e_dhit});
      chk("rnd_ramREN", {31'b0, ramREN}, {31'b0, e_ren});
      chk("rnd_ramWEN", {31'b0, ramWEN}, {31'b0, e_wen});
      chk("rnd_imemload", imemload, e_iload);
      chk("rnd_dmemload", dmemload, e_dload);
      if (e_ren || e_wen) chk("rnd_ramaddr", ramaddr, t_addr);
      if (e_wen) chk("rnd_ramstore", ramstore, t_store);

      if (t_active && n == t_hit) begin
`ifdef MEMORY_RESPONDER_IBUF_EN
        if (t_is_i && t_strobe) begin
          mb_valid = 1'b1; mb_tag = t_addr[31:2]; mb_data = t_cap;
        end
        if (t_wr && mb_valid && mb_tag == t_addr[31:2]) mb_valid = 1'b0;
`endif
        t_active = 1'b0;
      end

      dmemREN   = ($urandom_range(0, 3) == 0);
      dmemWEN   = ($urandom_range(0, 5) == 0);
      imemREN   = ($urandom_range(0, 1) == 0);
      halt      = ($urandom_range(0, 4) == 0);
      imemaddr  = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      dmemaddr  = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      dmemstore = $urandom;
      ramload   = $urandom;

      if (t_active && t_strobe && n == t_start + int'(LAT) - 1) t_cap = ramload;

      if (!t_active && n >= t_free) begin
        if (dmemREN || dmemWEN) begin
          t_active = 1'b1; t_is_i = 1'b0; t_wr = dmemWEN; t_strobe = 1'b1;
          t_addr = dmemaddr; t_store = dmemstore;
          t_start = n + 1; t_hit = n + int'(LAT) + 1; t_free = n + int'(LAT) + 2;
        end else if (imemREN && !halt) begin
          t_active = 1'b1; t_is_i = 1'b1; t_wr = 1'b0; t_strobe = 1'b1;
          t_addr = imemaddr; t_store = '0;
          t_start = n + 1; t_hit = n + int'(LAT) + 1; t_free = n + int'(LAT) + 2;
`ifdef MEMORY_RESPONDER_IBUF_EN
          if (mb_valid && mb_tag == imemaddr[31:2]) begin
            t_strobe = 1'b0; t_cap = mb_data;
            t_hit = n + 1; t_free = n + 2;
          end
`endif
        end
      end
    end

    idle_inputs();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter LAT, default 2, RAM access cycles per request, legal range 1..15.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port nRST  input  1  reset; synchronous and active-high (reset when 1).
REQ-004 SHALL have ports imemREN  input  1 and imemaddr  input  32: datapath instruction fetch request and byte address.
REQ-005 SHALL have ports dmemREN  input  1, dmemWEN  input  1, dmemaddr  input  32 and dmemstore  input  32: datapath data read, write, address and store data.
REQ-006 SHALL have port halt  input  1  datapath halted; no new fetches are accepted while it is 1.
REQ-007 SHALL have ports ihit  output  1 and imemload  output  32: fetch done and instruction word.
REQ-008 SHALL have ports dhit  output  1 and dmemload  output  32: data access done and load word.
REQ-009 SHALL have ports ramREN  output  1, ramWEN  output  1, ramaddr  output  32 and ramstore  output  32: registered RAM strobes, address and write data.
REQ-010 SHALL have port ramload  input  32  RAM read data, valid on the last cycle of an access window.

Function
REQ-011 SHALL implement FSM states IDLE, IACC, DACC and RESP.
REQ-012 IDLE, request sampled at edge k: any D request -> DACC; else imemREN with halt=0 -> IACC; else stay in IDLE.
REQ-013 Entering IACC or DACC SHALL latch address, store data and op, and clear a 4-bit counter.
REQ-014 ramaddr, ramstore, ramREN and ramWEN SHALL be driven from the latched values for exactly LAT cycles, then deasserted.
REQ-015 dmemWEN=1 selects ramWEN; otherwise ramREN; dmemWEN and dmemREN both 1 SHALL be treated as a write.
REQ-016 On the last ACC edge: go to RESP, register ramload into imemload or dmemload (reads only).
REQ-017 RESP SHALL last exactly one cycle with ihit or dhit =1 (never both), then return to IDLE.
REQ-018 RAM latency: request first high in cycle 0 -> hit in cycle LAT+1 (LAT=2 -> cycle 3).
REQ-019 imemload and dmemload SHALL hold their last value outside RESP; writes leave dmemload unchanged.
REQ-020 A request dropped mid-access SHALL NOT abort it; the access completes and the hit still pulses.
REQ-021 A request still high in the cycle after RESP SHALL be treated as a new request.
REQ-022 While halt=1, an IACC already started SHALL complete; D requests SHALL still be served.

Reset
REQ-023 nRST=1 at an edge SHALL force IDLE and counter=0, and clear ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr and ramstore to 0.
REQ-024 Reset mid-access SHALL abandon the access with no hit; the first request after reset SHALL be sampled normally.

Configuration
REQ-025 Macro MEMORY_RESPONDER_IBUF_EN defined: one-entry fetch buffer (valid bit, 30-bit word tag, 32-bit data), filled on every completed IACC.
REQ-026 With the buffer: in IDLE, no D request, imemREN=1, halt=0 and a valid tag matching imemaddr[31:2] -> RESP next cycle, ihit in cycle 1, no RAM strobes.
REQ-027 With the buffer: a completed write with dmemaddr[31:2] equal to the tag SHALL clear valid; reset SHALL clear valid.
REQ-028 Macro undefined: no buffer registers; every fetch SHALL use IACC.

Verification
REQ-029 LAT=2, imemREN=1 at 0x0000_0040 with ramload=0x2008_0005 -> ramREN high in cycles 1-2, ihit=1 in cycle 3, imemload=0x2008_0005.
REQ-030 imemREN and dmemREN both high, dmemaddr=0x100 -> dhit first in cycle 3, ihit in cycle 7, never both in one cycle.
REQ-031 dmemWEN=1, addr 0x200, store 0xDEAD_BEEF -> ramWEN, ramaddr=0x200 and ramstore=0xDEADBEEF for 2 cycles, dhit in cycle 3, dmemload unchanged.
REQ-032 nRST=1 in cycle 2 of a DACC -> all outputs 0 next cycle, no dhit; a new fetch afterwards gets ihit 3 cycles later.
REQ-033 IBUF_EN: fetch 0x40 twice -> second ihit 1 cycle after request with no ramREN; write to 0x40, then fetch 0x40 -> full LAT path again.
